// File: rtl/puf_ctrl.sv
`default_nettype none
// ============================================================================
// puf_ctrl -- sequences repeated PUF evaluations and majority-votes each bit
// Rev 1.0
// ============================================================================
module puf_ctrl #(
    parameter int LENGTH        = 8,
    parameter int RESP_BITS     = 8,
    parameter int REPEATS       = 5,
    parameter int CLEAR_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 6
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           abort,
    input  logic [LENGTH-1:0]              challenge,
    output logic [LENGTH-1:0]              puf_challenge,
    output logic                           puf_run,
    input  logic                           puf_result,
    output logic                           busy,
    output logic                           done,
    output logic [RESP_BITS-1:0]           response,
    output logic [$clog2(RESP_BITS+1)-1:0] unstable_count
);

    localparam int MAX_CYC = (CLEAR_CYCLES > SETTLE_CYCLES) ? CLEAR_CYCLES : SETTLE_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int BW      = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int RW      = (REPEATS > 1) ? $clog2(REPEATS) : 1;
    localparam int OW      = $clog2(REPEATS + 1);
    localparam int UW      = $clog2(RESP_BITS + 1);

    localparam logic [CW-1:0] CLEAR_LAST  = CW'(CLEAR_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST    = RW'(REPEATS - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(RESP_BITS - 1);
    localparam logic [OW-1:0] ONES_ALL    = OW'(REPEATS);
    localparam logic [OW-1:0] ONES_HALF   = OW'(REPEATS / 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        RUN    = 3'd2,
        SAMPLE = 3'd3,
        DECIDE = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [LENGTH-1:0] base;
    logic [BW-1:0]   bit_idx;
    logic [RW-1:0]   rep_idx;
    logic [CW-1:0]   cyc_cnt;
    logic [OW-1:0]   ones;
    logic [UW-1:0]   unstable;

    always_comb begin
        next_state    = state;
        busy          = (state != IDLE) && (state != DONE);
        done          = (state == DONE);
        puf_challenge = base + LENGTH'(bit_idx);
        unstable_count = unstable;
        case (state)
            IDLE:    if (start) next_state = CLEAR;
            CLEAR:   if (cyc_cnt == CLEAR_LAST) next_state = RUN;
            RUN:     if (cyc_cnt == SETTLE_LAST) next_state = SAMPLE;
            SAMPLE:  next_state = (rep_idx == REP_LAST) ? DECIDE : CLEAR;
            DECIDE:  next_state = (bit_idx == BIT_LAST) ? DONE : CLEAR;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        // abort wins over start and every other transition
        if (abort) next_state = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            puf_run  <= 1'b0;
            base     <= '0;
            bit_idx  <= '0;
            rep_idx  <= '0;
            cyc_cnt  <= '0;
            ones     <= '0;
            response <= '0;
            unstable <= '0;
        end else begin
            state   <= next_state;
            puf_run <= (next_state == RUN) || (next_state == SAMPLE);
            if (abort) begin
                rep_idx <= '0;
                cyc_cnt <= '0;
                ones    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            base     <= challenge;
                            response <= '0;
                            unstable <= '0;
                            bit_idx  <= '0;
                            rep_idx  <= '0;
                            cyc_cnt  <= '0;
                            ones     <= '0;
                        end
                    end
                    CLEAR:  cyc_cnt <= (cyc_cnt == CLEAR_LAST) ? '0 : cyc_cnt + 1'b1;
                    RUN:    cyc_cnt <= (cyc_cnt == SETTLE_LAST) ? '0 : cyc_cnt + 1'b1;
                    SAMPLE: begin
                        ones <= ones + OW'(puf_result);
                        if (rep_idx != REP_LAST) rep_idx <= rep_idx + 1'b1;
                    end
                    DECIDE: begin
                        response[bit_idx] <= (ones > ONES_HALF);
                        if ((ones != '0) && (ones != ONES_ALL)) unstable <= unstable + 1'b1;
                        ones    <= '0;
                        rep_idx <= '0;
                        // bit index parks on the last bit rather than wrapping
                        if (bit_idx != BIT_LAST) bit_idx <= bit_idx + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_puf_ctrl.sv
`default_nettype none
// ============================================================================
// tb_puf_ctrl -- directed bench for puf_ctrl with a behavioural PUF stub
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_puf_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] challenge = 8'h00;
    logic [7:0] puf_challenge;
    logic       puf_run;
    logic       puf_result;
    logic       busy;
    logic       done;
    logic [7:0] response;
    logic [3:0] unstable_count;

    int mode = 0;
    int eval_cnt = 0;
    int eval_base = 0;
    logic run_q = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int lat, nd, se;

    puf_ctrl #(
        .LENGTH(8), .RESP_BITS(8), .REPEATS(5), .CLEAR_CYCLES(4), .SETTLE_CYCLES(6)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .challenge(challenge), .puf_challenge(puf_challenge), .puf_run(puf_run),
        .puf_result(puf_result), .busy(busy), .done(done),
        .response(response), .unstable_count(unstable_count)
    );

    always #5 clk = ~clk;

    // evaluation counter: steps once after each falling edge of puf_run
    always @(posedge clk) begin
        run_q <= puf_run;
        if (run_q && !puf_run) eval_cnt <= eval_cnt + 1;
    end

    always_comb begin
        case (mode)
            0:       puf_result = 1'b1;
            1:       puf_result = puf_run & puf_challenge[0];
            default: puf_result = ((((eval_cnt - eval_base) % 5) % 2) == 0);
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // kind: 0 normal, 1 abort at stop_at, 2 reset at stop_at, 3 stray starts at 50/300
    task automatic run_req(input logic [7:0] ch, input int kind, input int stop_at,
                           output int lat_o, output int ndone, output int step_err);
        int step;
        logic [7:0] last;
        lat_o = 0; ndone = 0; step_err = 0; step = -1; last = 8'h00;
        eval_base = eval_cnt;
        @(negedge clk);
        challenge = ch;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        challenge = ~ch;
        for (int n = 1; n <= 1000; n++) begin
            if (done) begin
                ndone++;
                if (lat_o == 0) lat_o = n;
            end
            if (puf_run && (step < 0 || puf_challenge != last)) begin
                step++;
                if (puf_challenge !== ch + 8'(step)) step_err++;
                last = puf_challenge;
            end
            if ((kind == 1 || kind == 2) && n == stop_at) begin
                check("pre_stop_run", {31'd0, puf_run}, 32'd1);
                if (kind == 1) abort = 1'b1;
                else reset = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                reset = 1'b0;
                return;
            end
            start = (kind == 3 && (n == 50 || n == 300));
            if (kind == 0 && lat_o != 0) begin
                if (step != 7) step_err++;
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (step != 7) step_err++;
    endtask

    task automatic watch(input int cycles, output int ndone);
        ndone = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_run", {31'd0, puf_run}, 0);
        check("rst_resp", response, 0);
        check("rst_unstable", unstable_count, 0);
        check("rst_chal", puf_challenge, 0);

        mode = 0;
        run_req(8'h00, 0, 0, lat, nd, se);
        check("ones_latency", lat, 449);
        check("ones_resp", response, 8'hFF);
        check("ones_unstable", unstable_count, 0);
        check("ones_busy_in_done", {31'd0, busy}, 0);
        check("ones_steps", se, 0);
        @(negedge clk);
        check("ones_done_single", {31'd0, done}, 0);
        check("ones_hold", response, 8'hFF);

        mode = 1;
        run_req(8'h00, 0, 0, lat, nd, se);
        check("lsb_latency", lat, 449);
        check("lsb_resp", response, 8'hAA);
        check("lsb_unstable", unstable_count, 0);
        check("lsb_steps", se, 0);
        run_req(8'hFC, 0, 0, lat, nd, se);
        check("wrap_resp", response, 8'hAA);
        check("wrap_steps", se, 0);

        mode = 2;
        run_req(8'h00, 0, 0, lat, nd, se);
        check("alt_resp", response, 8'hFF);
        check("alt_unstable", unstable_count, 8);

        mode = 0;
        run_req(8'h00, 1, 100, lat, nd, se);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_run", {31'd0, puf_run}, 0);
        check("abort_done", {31'd0, done}, 0);
        check("abort_partial", response, 8'h01);
        check("abort_unstable", unstable_count, 0);
        check("abort_pre_done", nd, 0);
        watch(500, nd);
        check("abort_no_done", nd, 0);
        run_req(8'h00, 0, 0, lat, nd, se);
        check("after_abort_latency", lat, 449);
        check("after_abort_resp", response, 8'hFF);

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("idle_abort_busy", {31'd0, busy}, 0);
        check("idle_abort_run", {31'd0, puf_run}, 0);

        run_req(8'h00, 3, 0, lat, nd, se);
        check("stray_done_count", nd, 1);
        check("stray_latency", lat, 449);
        check("stray_steps", se, 0);
        check("stray_resp", response, 8'hFF);

        run_req(8'h10, 2, 120, lat, nd, se);
        check("mrst_run", {31'd0, puf_run}, 0);
        check("mrst_busy", {31'd0, busy}, 0);
        check("mrst_done", {31'd0, done}, 0);
        check("mrst_resp", response, 0);
        check("mrst_unstable", unstable_count, 0);
        check("mrst_chal", puf_challenge, 0);
        watch(500, nd);
        check("mrst_no_done", nd, 0);
        mode = 1;
        run_req(8'h00, 0, 0, lat, nd, se);
        check("mrst_after_latency", lat, 449);
        check("mrst_after_resp", response, 8'hAA);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
